// File: rtl/esc_pwm_writer_if.sv
// rtl/esc_pwm_writer_if.sv - command strobe bundle between the receiver reader and the ESC pulse writer
interface esc_pwm_writer_if #(
   parameter int COUNTER_SIZE = 8
) ();
   logic [COUNTER_SIZE-1:0] cmd_in;
   logic                    cmd_valid;

   modport master (output cmd_in, output cmd_valid);
   modport slave  (input  cmd_in, input  cmd_valid);
endinterface

// File: rtl/esc_pwm_writer.sv
// rtl/esc_pwm_writer.sv - 50 Hz ESC pulse regenerator with clamped, frame-aligned shadow commands
// Minimum-throttle failsafe after missed command frames is built when ESC_FAILSAFE_EN is defined.
module esc_pwm_writer #(
   parameter int COUNTER_SIZE    = 8,
   parameter int DIVIDER_SIZE    = 1330,
   parameter int FRAME_WIDTH     = 10,
   parameter int MIN_TICKS       = 40,
   parameter int MAX_CMD         = 40,
   parameter int FRAME_TICKS     = 800,
   parameter int FAILSAFE_FRAMES = 25
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   esc_pwm_writer_if.slave cmd,
   output logic            pwm_out,
   output logic            frame_start,
   output logic            failsafe
);
   localparam int DIV_W = (DIVIDER_SIZE > 0) ? $clog2(DIVIDER_SIZE + 1) : 1;
   localparam logic [FRAME_WIDTH-1:0]  LAST_TICK = FRAME_WIDTH'(FRAME_TICKS - 1);
   localparam logic [FRAME_WIDTH-1:0]  HIGH_BASE = FRAME_WIDTH'(MIN_TICKS);
   localparam logic [COUNTER_SIZE-1:0] CMD_CEIL  = COUNTER_SIZE'(MAX_CMD);

   if (MIN_TICKS + MAX_CMD >= FRAME_TICKS || FRAME_TICKS > (1 << FRAME_WIDTH) || FAILSAFE_FRAMES < 1) begin : g_param_check
      $error("esc_pwm_writer: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, RUN, FAILSAFE} state_t;

   state_t                  state_q, state_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [FRAME_WIDTH-1:0]  tick_cnt_q, tick_cnt_d;
   logic [COUNTER_SIZE-1:0] pending_q, pending_d;
   logic [COUNTER_SIZE-1:0] active_q, active_d;
   logic [COUNTER_SIZE-1:0] cmd_clamped;
   logic                    pwm_q, pwm_d;
   logic                    frame_start_q, frame_start_d;
   logic                    tick;

`ifdef ESC_FAILSAFE_EN
   localparam int MISS_W = $clog2(FAILSAFE_FRAMES + 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(FAILSAFE_FRAMES - 1);
   localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(FAILSAFE_FRAMES);
   logic [MISS_W-1:0] miss_q, miss_d;
`endif

   always_comb begin
      tick          = (div_q == '0);
      div_d         = tick ? DIV_W'(DIVIDER_SIZE) : div_q - 1'b1;
      cmd_clamped   = (cmd.cmd_in > CMD_CEIL) ? CMD_CEIL : cmd.cmd_in;
      pending_d     = cmd.cmd_valid ? cmd_clamped : pending_q;
      state_d       = state_q;
      tick_cnt_d    = tick_cnt_q;
      active_d      = active_q;
      pwm_d         = pwm_q;
      frame_start_d = 1'b0;
`ifdef ESC_FAILSAFE_EN
      miss_d        = cmd.cmd_valid ? '0 : miss_q;
`endif
      if (state_q == IDLE) begin
         tick_cnt_d = LAST_TICK;
         pwm_d      = 1'b0;
         if (cmd.cmd_valid) state_d = RUN;
      end else begin
         if (cmd.cmd_valid) state_d = RUN;
         if (tick) begin
            if (tick_cnt_q == LAST_TICK) begin
               tick_cnt_d    = '0;
               frame_start_d = 1'b1;
               if (cmd.cmd_valid) begin
                  active_d = cmd_clamped;
               end else begin
                  active_d = pending_q;
`ifdef ESC_FAILSAFE_EN
                  if (miss_q != MISS_MAX) miss_d = miss_q + 1'b1;
                  // active is parked at zero in failsafe so a return to RUN mid-frame cannot re-raise the pulse
                  if (miss_q >= MISS_LAST) begin
                     state_d  = FAILSAFE;
                     active_d = '0;
                  end
`endif
               end
            end else begin
               tick_cnt_d = tick_cnt_q + 1'b1;
            end
            pwm_d = (tick_cnt_d < HIGH_BASE + FRAME_WIDTH'(active_d));
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q       <= IDLE;
         div_q         <= DIV_W'(DIVIDER_SIZE);
         tick_cnt_q    <= LAST_TICK;
         pending_q     <= '0;
         active_q      <= '0;
         pwm_q         <= 1'b0;
         frame_start_q <= 1'b0;
`ifdef ESC_FAILSAFE_EN
         miss_q        <= '0;
`endif
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         tick_cnt_q    <= tick_cnt_d;
         pending_q     <= pending_d;
         active_q      <= active_d;
         pwm_q         <= pwm_d;
         frame_start_q <= frame_start_d;
`ifdef ESC_FAILSAFE_EN
         miss_q        <= miss_d;
`endif
      end
   end

   assign pwm_out     = pwm_q;
   assign frame_start = frame_start_q;
`ifdef ESC_FAILSAFE_EN
   assign failsafe    = (state_q == FAILSAFE);
`else
   assign failsafe    = 1'b0;
`endif
endmodule

// File: tb/tb_esc_pwm_writer.sv
// tb/tb_esc_pwm_writer.sv - directed self-checking bench for esc_pwm_writer
// Expected failsafe behaviour follows ESC_FAILSAFE_EN.
module tb_esc_pwm_writer;
   logic sys_clk;
   logic sys_rst;
   logic pwm_out;
   logic frame_start;
   logic failsafe;
   int   checks;
   int   errors;
   int   hi;
   int   lo;
   int   seen_pwm;
   int   seen_fs;
   int   seen_fail;

`ifdef ESC_FAILSAFE_EN
   localparam int FS_HI  = 16;
   localparam int FS_FLG = 1;
`else
   localparam int FS_HI  = 32;
   localparam int FS_FLG = 0;
`endif

   esc_pwm_writer_if #(.COUNTER_SIZE(8)) cmd_if ();

   esc_pwm_writer #(
      .COUNTER_SIZE    (8),
      .DIVIDER_SIZE    (3),
      .FRAME_WIDTH     (10),
      .MIN_TICKS       (4),
      .MAX_CMD         (4),
      .FRAME_TICKS     (16),
      .FAILSAFE_FRAMES (2)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .cmd         (cmd_if.slave),
      .pwm_out     (pwm_out),
      .frame_start (frame_start),
      .failsafe    (failsafe)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [7:0] v);
      cmd_if.cmd_valid = en;
      if (en) cmd_if.cmd_in = v;
   endtask

   task automatic strobe(input logic [7:0] v);
      drive(1'b1, v);
      @(negedge sys_clk);
      drive(1'b0, v);
   endtask

   task automatic watch_idle(input int n);
      seen_pwm = 0; seen_fs = 0; seen_fail = 0;
      repeat (n) begin
         @(negedge sys_clk);
         if (pwm_out !== 1'b0) seen_pwm++;
         if (frame_start !== 1'b0) seen_fs++;
         if (failsafe !== 1'b0) seen_fail++;
      end
   endtask

   // Called on a negedge; returns high/low cycle counts of one frame, ending on the next frame_start.
   // A strobe of s_val is issued when the high (s_hi) or low (s_lo) count reaches the given index.
   task automatic measure(output int h, output int l, input int s_hi, input int s_lo, input logic [7:0] s_val);
      int n;
      n = 0; h = 0; l = 0;
      while (frame_start !== 1'b1 && n < 200) begin
         @(negedge sys_clk);
         n++;
      end
      while (pwm_out === 1'b1 && h < 200) begin
         drive(h == s_hi, s_val);
         h++;
         @(negedge sys_clk);
      end
      while (frame_start !== 1'b1 && l < 200) begin
         drive(l == s_lo, s_val);
         l++;
         @(negedge sys_clk);
      end
      cmd_if.cmd_valid = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      cmd_if.cmd_in = 8'd0;
      cmd_if.cmd_valid = 1'b0;
      sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      check("reset_pwm", int'(pwm_out), 0);
      check("reset_frame_start", int'(frame_start), 0);
      check("reset_failsafe", int'(failsafe), 0);
      sys_rst = 1'b0;

      watch_idle(200);
      check("idle_pwm", seen_pwm, 0);
      check("idle_frame_start", seen_fs, 0);
      check("idle_failsafe", seen_fail, 0);

      strobe(8'd2);
      measure(hi, lo, -1, -1, 8'd0);
      check("cmd2_hi_first", hi, 24);
      check("cmd2_lo_first", lo, 40);
      measure(hi, lo, -1, -1, 8'd0);
      check("cmd2_hi_repeat", hi, 24);
      check("cmd2_lo_repeat", lo, 40);

      strobe(8'd200);
      measure(hi, lo, -1, -1, 8'd0);
      check("clamp_hi", hi, 32);
      check("clamp_lo", lo, 32);

      strobe(8'd0);
      measure(hi, lo, -1, -1, 8'd0);
      check("cmd0_hi", hi, 16);
      check("cmd0_lo", lo, 48);

      strobe(8'd1);
      measure(hi, lo, -1, -1, 8'd0);
      check("cmd1_hi", hi, 20);
      measure(hi, lo, 7, -1, 8'd3);
      check("midframe_hi_unchanged", hi, 20);
      check("midframe_lo_unchanged", lo, 44);
      measure(hi, lo, -1, 35, 8'd4);
      check("cmd3_hi_next_frame", hi, 28);
      check("cmd3_lo_next_frame", lo, 36);

      measure(hi, lo, -1, -1, 8'd0);
      check("wrap_bypass_hi", hi, 32);
      measure(hi, lo, -1, -1, 8'd0);
      check("miss1_hi", hi, 32);
      check("miss1_failsafe", int'(failsafe), 0);
      measure(hi, lo, -1, -1, 8'd0);
      check("miss2_hi", hi, FS_HI);
      check("miss2_failsafe", int'(failsafe), FS_FLG);

      strobe(8'd3);
      check("recover_failsafe_drop", int'(failsafe), 0);
      measure(hi, lo, -1, -1, 8'd0);
      check("recover_hi", hi, 28);

      repeat (2) @(negedge sys_clk);
      check("pre_reset_pwm", int'(pwm_out), 1);
      #2 sys_rst = 1'b1;
      #1;
      check("async_reset_pwm", int'(pwm_out), 0);
      check("async_reset_frame_start", int'(frame_start), 0);
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      watch_idle(100);
      check("post_reset_idle_pwm", seen_pwm, 0);
      check("post_reset_idle_frame_start", seen_fs, 0);
      strobe(8'd1);
      measure(hi, lo, -1, -1, 8'd0);
      check("post_reset_cmd1_hi", hi, 20);
      check("post_reset_cmd1_lo", lo, 44);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
